// File: rtl/data_mem_ctrl.sv
// Handshaked 2**A x W data memory with wait states, registered read data and post-reset clear.
// Optional even-parity protection is built when DMEM_PARITY_EN is defined.
module data_mem_ctrl #(
    parameter int unsigned W    = 8,
    parameter int unsigned A    = 8,
    parameter int unsigned WAIT = 0
) (
    input  logic         Clk,
    input  logic         Reset_n,
    input  logic         Req,
    input  logic         WriteEn,
    input  logic [A-1:0] Address,
    input  logic [W-1:0] DataIn,
`ifdef DMEM_PARITY_EN
    input  logic         ParInject,
    output logic         ParErr,
`endif
    output logic         Ready,
    output logic         Ack,
    output logic [W-1:0] DataOut,
    output logic         InitBusy
);

    localparam int unsigned Depth = 2 ** A;
`ifdef DMEM_PARITY_EN
    localparam int unsigned MW = W + 1;
`else
    localparam int unsigned MW = W;
`endif
    localparam logic [3:0] WaitLoad = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

    typedef enum logic [1:0] {
        StInit,
        StIdle,
        StBusy
    } state_e;

    state_e         state_q, state_d;
    logic [A-1:0]   ptr_q, ptr_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           ready_q, ready_d;
    logic           ack_q, ack_d;
    logic [W-1:0]   dout_q, dout_d;
    logic           busy_q, busy_d;
    logic [A-1:0]   hold_addr_q, hold_addr_d;
    logic           hold_we_q, hold_we_d;
    logic [W-1:0]   hold_din_q, hold_din_d;
`ifdef DMEM_PARITY_EN
    logic           hold_pinj_q, hold_pinj_d;
    logic           perr_q, perr_d;
    logic           exec_pinj;
`endif

    logic [MW-1:0]  mem_q [Depth];
    logic           mem_we;
    logic [A-1:0]   mem_waddr;
    logic [MW-1:0]  mem_wdata;
    logic [MW-1:0]  rd_word;

    logic           accept;
    logic           exec;
    logic [A-1:0]   exec_addr;
    logic           exec_we;
    logic [W-1:0]   exec_din;

    // ready_q is high exactly while in StIdle
    assign accept = Req & ready_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        ready_d     = ready_q;
        ack_d       = 1'b0;
        dout_d      = dout_q;
        busy_d      = busy_q;
        hold_addr_d = hold_addr_q;
        hold_we_d   = hold_we_q;
        hold_din_d  = hold_din_q;
        exec        = 1'b0;
        exec_addr   = hold_addr_q;
        exec_we     = hold_we_q;
        exec_din    = hold_din_q;
        mem_we      = 1'b0;
        mem_waddr   = ptr_q;
        mem_wdata   = '0;
`ifdef DMEM_PARITY_EN
        hold_pinj_d = hold_pinj_q;
        exec_pinj   = hold_pinj_q;
        perr_d      = 1'b0;
`endif

        unique case (state_q)
            StInit: begin
                mem_we    = 1'b1;
                mem_waddr = ptr_q;
                mem_wdata = '0;
                ptr_d     = ptr_q + 1'b1;
                if (ptr_q == '1) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end
            end
            StIdle: begin
                if (accept) begin
                    hold_addr_d = Address;
                    hold_we_d   = WriteEn;
                    hold_din_d  = DataIn;
`ifdef DMEM_PARITY_EN
                    hold_pinj_d = ParInject;
`endif
                    if (WAIT == 0) begin
                        exec      = 1'b1;
                        exec_addr = Address;
                        exec_we   = WriteEn;
                        exec_din  = DataIn;
`ifdef DMEM_PARITY_EN
                        exec_pinj = ParInject;
`endif
                    end else begin
                        state_d = StBusy;
                        cnt_d   = WaitLoad;
                        ready_d = 1'b0;
                    end
                end
            end
            StBusy: begin
                if (cnt_q == 4'd0) begin
                    exec    = 1'b1;
                    state_d = StIdle;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = StInit;
        endcase

        rd_word = mem_q[exec_addr];
        if (exec) begin
            ack_d = 1'b1;
            if (exec_we) begin
                mem_we    = 1'b1;
                mem_waddr = exec_addr;
`ifdef DMEM_PARITY_EN
                mem_wdata = {(^exec_din) ^ exec_pinj, exec_din};
`else
                mem_wdata = exec_din;
`endif
            end else begin
                dout_d = rd_word[W-1:0];
`ifdef DMEM_PARITY_EN
                perr_d = (^rd_word[W-1:0]) != rd_word[W];
`endif
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= StInit;
            ptr_q       <= '0;
            cnt_q       <= 4'd0;
            ready_q     <= 1'b0;
            ack_q       <= 1'b0;
            dout_q      <= '0;
            busy_q      <= 1'b1;
            hold_addr_q <= '0;
            hold_we_q   <= 1'b0;
            hold_din_q  <= '0;
`ifdef DMEM_PARITY_EN
            hold_pinj_q <= 1'b0;
            perr_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            ack_q       <= ack_d;
            dout_q      <= dout_d;
            busy_q      <= busy_d;
            hold_addr_q <= hold_addr_d;
            hold_we_q   <= hold_we_d;
            hold_din_q  <= hold_din_d;
`ifdef DMEM_PARITY_EN
            hold_pinj_q <= hold_pinj_d;
            perr_q      <= perr_d;
`endif
        end
    end

    // Array has no reset; the INIT sweep clears it instead
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign Ready    = ready_q;
    assign Ack      = ack_q;
    assign DataOut  = dout_q;
    assign InitBusy = busy_q;
`ifdef DMEM_PARITY_EN
    assign ParErr   = perr_q;
`endif

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: three instances with WAIT = 0, 3, 5 (W=8, A=8).
// Parity checks are built when DMEM_PARITY_EN is defined.
module tb_data_mem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req   [3];
    logic       we    [3];
    logic [7:0] addr  [3];
    logic [7:0] din   [3];
    logic [7:0] dout  [3];
    logic       ready [3];
    logic       ack   [3];
    logic       ibusy [3];
`ifdef DMEM_PARITY_EN
    logic       pinj  [3];
    logic       perr  [3];
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       rd;
        logic [7:0] data;
        logic       perr;
        int         cyc;
    } exp_t;

    exp_t       sb      [3][$];
    logic [7:0] model   [3][256];
    logic       mpar    [3][256];
    logic [7:0] last_rd [3];
    int         ack_cnt [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        data_mem_ctrl #(
            .W   (8),
            .A   (8),
            .WAIT(g == 0 ? 0 : (g == 1 ? 3 : 5))
        ) u_dut (
            .Clk      (clk),
            .Reset_n  (rst_n),
            .Req      (req[g]),
            .WriteEn  (we[g]),
            .Address  (addr[g]),
            .DataIn   (din[g]),
`ifdef DMEM_PARITY_EN
            .ParInject(pinj[g]),
            .ParErr   (perr[g]),
`endif
            .Ready    (ready[g]),
            .Ack      (ack[g]),
            .DataOut  (dout[g]),
            .InitBusy (ibusy[g])
        );
    end

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : ((k == 1) ? 3 : 5);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 256; i++) begin
                model[k][i] = 8'h00;
                mpar[k][i]  = 1'b0;
            end
            last_rd[k] = 8'h00;
            sb[k].delete();
        end
    endtask

    // Drive a request and wait until it will be accepted at the next edge
    task automatic start_access(input int k, input logic w, input logic [7:0] a,
                                input logic [7:0] d, input logic pi);
        exp_t e;
        int   n = 0;
        req[k]  = 1'b1;
        we[k]   = w;
        addr[k] = a;
        din[k]  = d;
`ifdef DMEM_PARITY_EN
        pinj[k] = pi;
`endif
        while (!ready[k] && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check($sformatf("accept_wait%0d", k), {31'b0, ready[k]}, 32'd1);
        if (ready[k]) begin
            e.rd   = !w;
            e.perr = 1'b0;
            e.cyc  = cyc + 1 + wait_of(k);
            if (w) begin
                e.data      = last_rd[k];
                model[k][a] = d;
                mpar[k][a]  = pi;
            end else begin
                e.data     = model[k][a];
                e.perr     = mpar[k][a];
                last_rd[k] = model[k][a];
            end
            sb[k].push_back(e);
        end
    endtask

    task automatic end_req(input int k);
        @(posedge clk);
        #1;
        req[k] = 1'b0;
    endtask

    task automatic wait_done(input int k);
        int n = 0;
        while (sb[k].size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check($sformatf("ack_wait%0d", k), sb[k].size(), 32'd0);
    endtask

    task automatic access(input int k, input logic w, input logic [7:0] a,
                          input logic [7:0] d, input logic pi);
        start_access(k, w, a, d, pi);
        end_req(k);
        wait_done(k);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        for (int k = 0; k < 3; k++) begin
            if (ack[k] === 1'b1) begin
                ack_cnt[k]++;
                check($sformatf("ack_expected%0d", k), {31'b0, sb[k].size() > 0}, 32'd1);
                if (sb[k].size() > 0) begin
                    e = sb[k].pop_front();
                    check($sformatf("dataout%0d", k), {24'b0, dout[k]}, {24'b0, e.data});
                    check($sformatf("ack_cycle%0d", k), cyc, e.cyc);
`ifdef DMEM_PARITY_EN
                    check($sformatf("parerr%0d", k), {31'b0, perr[k]}, {31'b0, e.perr});
`endif
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int icnt [3];
        int ibad [3];
        int a0;
        int n;

        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req[k] = 1'b0; we[k] = 1'b0; addr[k] = 8'h00; din[k] = 8'h00;
`ifdef DMEM_PARITY_EN
            pinj[k] = 1'b0;
`endif
            ack_cnt[k] = 0; icnt[k] = 0; ibad[k] = 0;
        end
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            check("rst_ready", {31'b0, ready[k]}, 32'd0);
            check("rst_ack", {31'b0, ack[k]}, 32'd0);
            check("rst_dout", {24'b0, dout[k]}, 32'd0);
            check("rst_initbusy", {31'b0, ibusy[k]}, 32'd1);
`ifdef DMEM_PARITY_EN
            check("rst_parerr", {31'b0, perr[k]}, 32'd0);
`endif
        end

        // 1: clear sequence lasts exactly 256 cycles with Ready low
        rst_n = 1'b1;
        for (int c = 0; c < 300; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (ibusy[k]) icnt[k]++;
                if (ibusy[k] && ready[k]) ibad[k]++;
            end
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 3; k++) begin
            check("init_cycles", icnt[k], 32'd256);
            check("init_ready_low", ibad[k], 32'd0);
            check("init_ready_after", {31'b0, ready[k]}, 32'd1);
        end
        for (int k = 0; k < 3; k++) access(k, 1'b0, 8'hFF, 8'h00, 1'b0);
        check("t1_dout", {24'b0, dout[2]}, 32'h00);

        // 2: WAIT=0 write then read
        access(0, 1'b1, 8'h10, 8'hA5, 1'b0);
        access(0, 1'b0, 8'h10, 8'h00, 1'b0);
        check("t2_dout", {24'b0, dout[0]}, 32'hA5);

        // 3: WAIT=3 read; Ready low for three cycles, then Ready and Ack together
        access(1, 1'b1, 8'h10, 8'h5A, 1'b0);
        start_access(1, 1'b0, 8'h10, 8'h00, 1'b0);
        end_req(1);
        for (int i = 0; i < 3; i++) begin
            check("t3_ready_low", {31'b0, ready[1]}, 32'd0);
            check("t3_ack_low", {31'b0, ack[1]}, 32'd0);
            @(posedge clk);
            #1;
        end
        check("t3_ready_back", {31'b0, ready[1]}, 32'd1);
        check("t3_ack", {31'b0, ack[1]}, 32'd1);
        wait_done(1);
        check("t3_dout", {24'b0, dout[1]}, 32'h5A);

        // 4: Req held high across a write and a following read
        a0 = ack_cnt[1];
        start_access(1, 1'b1, 8'h20, 8'h3C, 1'b0);
        @(posedge clk);
        #1;
        start_access(1, 1'b0, 8'h20, 8'h00, 1'b0);
        check("t4_ack_with_ready", {31'b0, ack[1]}, 32'd1);
        end_req(1);
        wait_done(1);
        check("t4_ack_pulses", ack_cnt[1] - a0, 32'd2);
        check("t4_dout", {24'b0, dout[1]}, 32'h3C);

`ifdef DMEM_PARITY_EN
        // 6: parity injection and recovery
        access(0, 1'b1, 8'h02, 8'h01, 1'b1);
        access(0, 1'b0, 8'h02, 8'h00, 1'b0);
        check("t6_dout", {24'b0, dout[0]}, 32'h01);
        access(0, 1'b1, 8'h02, 8'h01, 1'b0);
        access(0, 1'b0, 8'h02, 8'h00, 1'b0);
        check("t6_parerr_clear", {31'b0, perr[0]}, 32'd0);
`endif

        // 5: reset during a WAIT=5 write drops it
        start_access(2, 1'b1, 8'h05, 8'h77, 1'b0);
        end_req(2);
        @(posedge clk);
        #1;
        check("t5_busy", {31'b0, ready[2]}, 32'd0);
        rst_n = 1'b0;
        clear_model();
        a0 = ack_cnt[2];
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n = 0;
        while (ibusy[2] && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("t5_init_done", {31'b0, ibusy[2]}, 32'd0);
        check("t5_no_ack", ack_cnt[2], a0);
        access(2, 1'b0, 8'h05, 8'h00, 1'b0);
        check("t5_dout", {24'b0, dout[2]}, 32'h00);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
